// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the write-back port arbiter and its source FIFOs.
package wb_port_arbiter_pkg;

    localparam int NUM_REQ    = 4;
    localparam int NUM_PORTS  = 3;
    localparam int DATA_W     = 32;
    localparam int PREG_W     = 7;
    localparam int RS_IDX_W   = 5;
    localparam int FIFO_DEPTH = 2;

    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PORT_W = $clog2(NUM_PORTS + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam int WB_SRC_ALU0 = 0;
    localparam int WB_SRC_ALU1 = 1;
    localparam int WB_SRC_MUL  = 2;
    localparam int WB_SRC_LOAD = 3;

    typedef struct packed {
        logic [PREG_W-1:0]   dst_index;
        logic [DATA_W-1:0]   dst_val;
        logic [RS_IDX_W-1:0] rs_entry;
    } wb_req_t;

    // Source visited k steps after the rotating start point.
    function automatic logic [SRC_W-1:0] scan_src(input logic [SRC_W-1:0] base, input int k);
        int t;
        t = int'(base) + k;
        return SRC_W'(t % NUM_REQ);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_src_fifo.sv
// Small per-source result buffer. Push/pop qualification is owned by the parent;
// flush empties the buffer and wins over any push or pop in the same cycle.
module wb_src_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  wb_req_t          push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output wb_req_t          head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; a flush resets pointers so the head reads slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (pop) r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write/bypass ports among the execute result sources.
// Each source is buffered; non-empty heads are granted in rotating order and the
// rotation restarts at the first head that missed out, bounding its wait.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][PREG_W-1:0]       req_dst_index,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]       req_dst_val,
    input  logic [NUM_REQ-1:0][RS_IDX_W-1:0]     req_rs_entry,
    output logic [NUM_PORTS-1:0]                 wb_valid,
    output logic [NUM_PORTS-1:0][PREG_W-1:0]     wb_dst_index,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]     wb_dst_val,
    output logic [NUM_PORTS-1:0]                 free_en,
    output logic [NUM_PORTS-1:0][RS_IDX_W-1:0]   free_entry
);

    logic [SRC_W-1:0]   r_rr_ptr;

    wb_req_t            w_push_data [NUM_REQ];
    wb_req_t            w_head      [NUM_REQ];
    logic [CNT_W-1:0]   w_count     [NUM_REQ];
    logic [NUM_REQ-1:0] w_push;
    logic [NUM_REQ-1:0] w_pop;
    logic [NUM_REQ-1:0] w_nonempty;

    logic [NUM_PORTS-1:0] w_wb_valid;
    wb_req_t              w_port_data [NUM_PORTS];
    logic                 w_skip_found;
    logic [SRC_W-1:0]     w_skip_ptr;
    logic [PORT_W-1:0]    w_nport;
    logic [SRC_W-1:0]     w_src;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
            // Ready comes from the registered count only, so a full FIFO refuses
            // even when its head is being drained this cycle.
            assign req_ready[gi]  = (w_count[gi] < CNT_W'(FIFO_DEPTH));
            assign w_nonempty[gi] = (w_count[gi] != '0);
            assign w_push[gi]     = req_valid[gi] & req_ready[gi] & ~flush;
            assign w_push_data[gi] = '{dst_index: req_dst_index[gi],
                                       dst_val:   req_dst_val[gi],
                                       rs_entry:  req_rs_entry[gi]};

            wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
                .clk       (clk),
                .rst_n     (rst),
                .flush     (flush),
                .push      (w_push[gi]),
                .push_data (w_push_data[gi]),
                .pop       (w_pop[gi]),
                .count     (w_count[gi]),
                .head      (w_head[gi])
            );
        end
    endgenerate

    // Rotating scan: first NUM_PORTS non-empty heads fill ports in order; the first
    // head left over becomes the next scan start. Flush suppresses all grants.
    always_comb begin
        w_pop        = '0;
        w_wb_valid   = '0;
        w_skip_found = 1'b0;
        w_skip_ptr   = r_rr_ptr;
        w_nport      = '0;
        w_src        = '0;
        for (int p = 0; p < NUM_PORTS; p++) w_port_data[p] = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_src = scan_src(r_rr_ptr, k);
            if (w_nonempty[w_src]) begin
                if (w_nport < PORT_W'(NUM_PORTS)) begin
                    w_wb_valid[w_nport]  = 1'b1;
                    w_port_data[w_nport] = w_head[w_src];
                    w_pop[w_src]         = 1'b1;
                    w_nport              = w_nport + 1'b1;
                end else if (!w_skip_found) begin
                    w_skip_found = 1'b1;
                    w_skip_ptr   = w_src;
                end
            end
        end
        if (flush) begin
            w_pop        = '0;
            w_wb_valid   = '0;
            w_skip_found = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) w_port_data[p] = '0;
        end
    end

    // Rotation pointer moves only when some waiting head was left ungranted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_skip_found) begin
            r_rr_ptr <= w_skip_ptr;
        end
    end

    assign wb_valid = w_wb_valid;
    assign free_en  = w_wb_valid;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign wb_dst_index[gi] = w_port_data[gi].dst_index;
            assign wb_dst_val[gi]   = w_port_data[gi].dst_val;
            assign free_entry[gi]   = w_port_data[gi].rs_entry;
        end
    endgenerate

endmodule
